// File: rtl/alu_multicycle_if.sv
// Handshake and data bundle between the register-read stage, the ALU and writeback.
interface alu_multicycle_if #(
  parameter int N = 64
);
  logic         InValid;
  logic         InReady;
  logic [3:0]   ALUCtrl;
  logic [N-1:0] BusA;
  logic [N-1:0] BusB;
  logic         OutValid;
  logic         OutReady;
  logic [N-1:0] BusW;
  logic         Zero;
  logic         Neg;
  logic         Carry;
  logic         Ovf;
  logic         Illegal;

  modport master (
    output InValid, ALUCtrl, BusA, BusB, OutReady,
    input  InReady, OutValid, BusW, Zero, Neg, Carry, Ovf, Illegal
  );

  modport slave (
    input  InValid, ALUCtrl, BusA, BusB, OutReady,
    output InReady, OutValid, BusW, Zero, Neg, Carry, Ovf, Illegal
  );
endinterface

// File: rtl/alu_multicycle.sv
// Registered ALU with NZCV flags and an iterative shift-add multiplier.
//
// state | meaning
// ------+-----------------------------------------------------------
// Idle  | ready for an operation (InReady=1)
// Mul   | shift-add multiply in progress, one multiplier bit per cycle
// Done  | result and flags presented (OutValid=1) until OutReady
module alu_multicycle #(
  parameter int N     = 64,
  parameter int LOGN  = 6,
  parameter bit MULEN = 1'b1
) (
  input logic           CLK,
  input logic           ResetL,
  alu_multicycle_if.slave bus
);

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpLsl   = 4'b0011;
  localparam logic [3:0] OpLsr   = 4'b0100;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpPassB = 4'b0111;
  localparam logic [3:0] OpMul   = 4'b1000;

  typedef enum logic [1:0] {Idle, Mul, Done} stateT;

  stateT state, nextState;

  logic [N-1:0]    busW;
  logic            carryReg, ovfReg, illegalReg;
  logic [N-1:0]    mulA, mulB, acc;
  logic [LOGN-1:0] mulCnt;

  logic            accept, isMul, mulLast;
  logic [N:0]      sumExt;
  logic [N-1:0]    diff, aluResult, accNext;
  logic            shiftOut;
  logic [LOGN-1:0] shAmt;
  logic            aluCarry, aluOvf, aluIllegal;

  assign accept  = bus.InValid & (state == Idle);
  assign isMul   = MULEN && (bus.ALUCtrl == OpMul);
  assign mulLast = (mulCnt == '0);
  assign accNext = acc + (mulB[0] ? mulA : '0);

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!ResetL) state <= Idle;
    else         state <= nextState;
  end

  // Next-state logic: Done always returns to Idle before another accept.
  always_comb begin
    nextState = state;
    case (state)
      Idle: if (accept) nextState = isMul ? Mul : Done;
      Mul:  if (mulLast) nextState = Done;
      Done: if (bus.OutReady) nextState = Idle;
      default: nextState = Idle;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    bus.InReady  = (state == Idle);
    bus.OutValid = (state == Done);
  end

  // Single-cycle operations; shift amount is the full BusB so any upper bit forces zero.
  always_comb begin
    sumExt     = {1'b0, bus.BusA} + {1'b0, bus.BusB};
    diff       = bus.BusA - bus.BusB;
    shiftOut   = |bus.BusB[N-1:LOGN];
    shAmt      = bus.BusB[LOGN-1:0];
    aluResult  = '0;
    aluCarry   = 1'b0;
    aluOvf     = 1'b0;
    aluIllegal = 1'b0;
    case (bus.ALUCtrl)
      OpAnd:   aluResult = bus.BusA & bus.BusB;
      OpOr:    aluResult = bus.BusA | bus.BusB;
      OpAdd: begin
        aluResult = sumExt[N-1:0];
        aluCarry  = sumExt[N];
        aluOvf    = (bus.BusA[N-1] == bus.BusB[N-1]) && (sumExt[N-1] != bus.BusA[N-1]);
      end
      OpLsl:   aluResult = shiftOut ? '0 : (bus.BusA << shAmt);
      OpLsr:   aluResult = shiftOut ? '0 : (bus.BusA >> shAmt);
      OpSub: begin
        aluResult = diff;
        aluCarry  = (bus.BusA >= bus.BusB);
        aluOvf    = (bus.BusA[N-1] != bus.BusB[N-1]) && (diff[N-1] != bus.BusA[N-1]);
      end
      OpPassB: aluResult = bus.BusB;
      OpMul:   aluIllegal = !MULEN;
      default: aluIllegal = 1'b1;
    endcase
  end

  // Result/flag registers and multiplier datapath; flags only change together with BusW.
  always_ff @(posedge CLK) begin
    if (!ResetL) begin
      busW       <= '0;
      carryReg   <= 1'b0;
      ovfReg     <= 1'b0;
      illegalReg <= 1'b0;
      mulA       <= '0;
      mulB       <= '0;
      acc        <= '0;
      mulCnt     <= '0;
    end else if (accept) begin
      if (isMul) begin
        mulA   <= bus.BusA;
        mulB   <= bus.BusB;
        acc    <= '0;
        mulCnt <= LOGN'(N - 1);
      end else begin
        busW       <= aluResult;
        carryReg   <= aluCarry;
        ovfReg     <= aluOvf;
        illegalReg <= aluIllegal;
      end
    end else if (state == Mul) begin
      acc    <= accNext;
      mulA   <= mulA << 1;
      mulB   <= mulB >> 1;
      mulCnt <= mulCnt - 1'b1;
      if (mulLast) begin
        busW       <= accNext;
        carryReg   <= 1'b0;
        ovfReg     <= 1'b0;
        illegalReg <= 1'b0;
      end
    end
  end

  assign bus.BusW    = busW;
  assign bus.Zero    = (busW == '0);
  assign bus.Neg     = busW[N-1];
  assign bus.Carry   = carryReg;
  assign bus.Ovf     = ovfReg;
  assign bus.Illegal = illegalReg;

endmodule
